// File: rtl/fault_sim_bist.sv
// ----------------------------------------------------------------------------
// fault_sim_bist
//
// Purpose:
//   Stuck-at fault-detection sequencer for combinational units under test.
//   One stimulus vector drives a fault-free UUT and its fault-injected twin.
//   Their outputs are compared once the vector has been held for SETTLE+1
//   cycles. The block counts compared and mismatching vectors and records the
//   first detecting vector. Patterns come from an exhaustive counter or from a
//   maximal-length Fibonacci LFSR. A run can optionally halt on the first
//   detection.
//
// Ports:
//   clk_i            rising-edge clock
//   rst_ni           asynchronous active-low reset
//   start_i          run request, honoured only when idle or done
//   mode_i           0 = exhaustive counter, 1 = LFSR (sampled with start)
//   stop_on_first_i  halt at the first mismatch (sampled with start)
//   good_out_i       output of the fault-free UUT
//   fault_out_i      output of the faulty UUT
//   vec_out_o        stimulus vector driving both UUTs
//   busy_o           run in progress
//   done_o           run finished, held until the next start
//   detected_o       at least one mismatch seen this run
//   first_vec_o      first vector that produced a mismatch
//   mismatch_cnt_o   number of mismatching vectors
//   vec_cnt_o        number of vectors compared
// ----------------------------------------------------------------------------
module fault_sim_bist #(
   parameter int              N_IN       = 4,
   parameter int              N_OUT      = 1,
   parameter int              SETTLE     = 1,
   parameter logic [N_IN-1:0] LFSR_TAPS  = 4'b1001,
   parameter logic [N_IN-1:0] LFSR_SEED  = 4'b0001
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              mode_i,
   input  logic              stop_on_first_i,
   input  logic [N_OUT-1:0]  good_out_i,
   input  logic [N_OUT-1:0]  fault_out_i,
   output logic [N_IN-1:0]   vec_out_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              detected_o,
   output logic [N_IN-1:0]   first_vec_o,
   output logic [N_IN:0]     mismatch_cnt_o,
   output logic [N_IN:0]     vec_cnt_o
);

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [N_IN-1:0] SEED_EFF  = (LFSR_SEED == '0) ? N_IN'(1) : LFSR_SEED;
   localparam logic [3:0]      HOLD_LAST = 4'(SETTLE);
   localparam logic [N_IN:0]   CNT_ONE   = (N_IN+1)'(1);
   localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e            state_q;
   logic              mode_q;
   logic              stop_q;
   logic [3:0]        hold_q;
   logic [N_IN-1:0]   vec_q;
   logic              busy_q;
   logic              done_q;
   logic              detected_q;
   logic [N_IN-1:0]   firstVec_q;
   logic [N_IN:0]     misCnt_q;
   logic [N_IN:0]     vecCnt_q;

   logic [N_IN-1:0]   lfsrNext_d;
   logic [N_IN-1:0]   vec_d;
   logic              last_d;
   logic              mis_d;
   logic              compare_d;

   // Successor vector and end-of-run detection. In LFSR mode the last vector
   // is the one whose successor would wrap back to the seed, which gives
   // 2^N_IN-1 distinct nonzero vectors for a primitive tap mask.
   always_comb begin
      lfsrNext_d = {vec_q[N_IN-2:0], ^(vec_q & LFSR_TAPS)};
      vec_d      = mode_q ? lfsrNext_d : (vec_q + VEC_ONE);
      last_d     = mode_q ? (lfsrNext_d == SEED_EFF) : (&vec_q);
      // A plain inequality; unknown UUT outputs are kept out by the environment.
      mis_d      = (good_out_i != fault_out_i);
      compare_d  = (hold_q == HOLD_LAST);
   end

   // Sequencer: a new run starts only from IDLE or DONE. In APPLY each vector
   // is held until the hold counter reaches SETTLE, compared on that cycle,
   // and then either advanced or the run is closed with vec_out frozen on the
   // last applied vector.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         mode_q     <= 1'b0;
         stop_q     <= 1'b0;
         hold_q     <= '0;
         vec_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         detected_q <= 1'b0;
         firstVec_q <= '0;
         misCnt_q   <= '0;
         vecCnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start_i) begin
                  mode_q     <= mode_i;
                  stop_q     <= stop_on_first_i;
                  hold_q     <= '0;
                  vec_q      <= mode_i ? SEED_EFF : '0;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  detected_q <= 1'b0;
                  firstVec_q <= '0;
                  misCnt_q   <= '0;
                  vecCnt_q   <= '0;
                  state_q    <= APPLY;
               end
            end
            APPLY: begin
               if (compare_d) begin
                  vecCnt_q <= vecCnt_q + CNT_ONE;
                  if (mis_d) begin
                     misCnt_q <= misCnt_q + CNT_ONE;
                  end
                  if (mis_d && !detected_q) begin
                     firstVec_q <= vec_q;
                     detected_q <= 1'b1;
                  end
                  if (last_d || (stop_q && mis_d)) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     vec_q  <= vec_d;
                     hold_q <= '0;
                  end
               end else begin
                  hold_q <= hold_q + 4'd1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign vec_out_o      = vec_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign detected_o     = detected_q;
   assign first_vec_o    = firstVec_q;
   assign mismatch_cnt_o = misCnt_q;
   assign vec_cnt_o      = vecCnt_q;

endmodule
